ahb_shared_bus_sequencer: RTL and testbench
===========================================

Name: ahb_shared_bus_sequencer

Overview:
- Multi-cycle bus front-end for the next-generation RISC-V core. Instruction fetch and data load/store share one AHB-Lite master port instead of separate instruction and data read buses.
- Sequences fetch → execute → optional data access and pulses `retire` so the core advances its PC.
- Supports wait states (HREADY), error responses (HRESP), a stuck-bus timeout and misalignment trapping.
- Sits between the core datapath/control unit and the AHB-Lite interconnect (memory, UART).

Parameters:
- ADDR_WIDTH, 32, width of HADDR, pc_in, mem_addr, err_addr.
- DATA_WIDTH, 32, AHB data width; legal values 32 or 64 only.
- TIMEOUT_CYCLES, 16, consecutive HREADY-low data-phase cycles before trapping; 0 disables the timeout.

Ports:
- clock  in  1  single clock; everything on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  start/continue sequencing from IDLE
- pc_in  in  ADDR_WIDTH  core PC, fetch address
- instr_out  out  32  registered fetched instruction
- instr_valid  out  1  1-cycle pulse in EXEC
- mem_req  in  1  sampled in EXEC only: instruction needs a data access
- mem_we  in  1  sampled in EXEC: 1 = store
- mem_size  in  2  sampled in EXEC: 00 byte, 01 half, 10 word, 11 dword (64-bit only)
- mem_addr  in  ADDR_WIDTH  sampled in EXEC
- mem_wdata  in  DATA_WIDTH  sampled in EXEC, already lane-aligned
- rdata  out  DATA_WIDTH  HRDATA passthrough, valid with rdata_valid
- rdata_valid  out  1  load completion pulse
- retire  out  1  1-cycle pulse; core updates PC/regfile on this edge
- bus_error  out  1  sticky trap flag
- err_addr  out  ADDR_WIDTH  address of trapping access
- HADDR  out  ADDR_WIDTH
- HTRANS  out  2  00 IDLE, 10 NONSEQ only
- HWRITE  out  1
- HSIZE  out  3
- HWDATA  out  DATA_WIDTH
- HRDATA  in  DATA_WIDTH
- HREADY  in  1
- HRESP  in  1

Behaviour:
- Reset is synchronous, active-low (reset=0 at a rising edge) and takes effect regardless of state. Any in-flight transfer is abandoned.
- Reset values:
  - state IDLE
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0
  - instr_out=32'h00000013
  - instr_valid, rdata_valid, retire, bus_error = 0
  - err_addr=0; timeout counter=0
- States:
  - IDLE → F_ADDR when enable=1.
  - F_ADDR (1 cycle): HTRANS=NONSEQ, HADDR=pc_in, HWRITE=0, HSIZE=010. Go to F_DATA.
  - F_DATA: wait for HREADY=1.
    - On HREADY=1 and HRESP=0: capture instr_out. If DATA_WIDTH=64, use lane HRDATA[63:32] when fetch HADDR[2]=1, else [31:0]. Go to EXEC.
  - EXEC (1 cycle): instr_valid=1; sample the mem_* inputs into registers.
    - mem_req=0: retire=1; next state F_ADDR if enable=1, else IDLE.
    - mem_req=1 and aligned and legal size: go to D_ADDR.
    - Otherwise: go to ERROR.
  - D_ADDR (1 cycle): HTRANS=NONSEQ, HADDR=addr_q, HWRITE=we_q, HSIZE={1'b0,size_q}. Go to D_DATA.
  - D_DATA: HWDATA=wdata_q, held stable for the whole data phase.
    - On HREADY=1, HRESP=0: retire=1; rdata_valid=1 if load. Next state F_ADDR/IDLE per enable.
  - ERROR: HTRANS=IDLE; bus_error=1. Exit only by reset; no retire.
- Outside address-phase states: HTRANS=00 and HADDR holds the last driven value.
- Alignment and size legality:
  - half requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0.
  - size 11 is illegal when DATA_WIDTH=32.
  - A misaligned or illegal access issues no bus transfer.
- Errors (from F_DATA or D_DATA):
  - HRESP=1 in any data-phase cycle → ERROR next cycle, regardless of HREADY.
  - Timeout: counter increments each data-phase cycle with HREADY=0 and clears on HREADY=1 or state exit. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0) → ERROR.
  - err_addr latches the address of the faulting phase, or mem_addr for an EXEC trap.
- Timing with zero wait states:
  - Non-memory instruction: 3 cycles.
  - Load/store: 5 cycles.
  - Each HREADY-low cycle adds 1 cycle.
- enable=0 is honoured only at retire; an in-progress instruction always completes.
- pc_in must be stable from F_ADDR through F_DATA. It may change on the retire edge.

Test Plan:
- Reset, then enable=1, pc_in=0x0, HREADY=1, HRDATA=0x00500093, mem_req=0 → NONSEQ fetch at 0x0 in cycle 1, instr_valid and retire in cycle 3, next fetch at cycle 4.
- Store: mem_req=1, mem_we=1, mem_size=10, mem_addr=0x1000, wdata=0xDEADBEEF, HREADY low 2 cycles → HWRITE=1, HSIZE=010, HWDATA held 3 cycles, retire on cycle 7.
- Load with DATA_WIDTH=64, fetch at 0x4: instr_out = HRDATA[63:32]. Then load addr=0x8 size 11 → rdata_valid with retire.
- Misaligned word at 0x1002 → no NONSEQ issued, bus_error=1, err_addr=0x1002, no retire thereafter.
- HRESP=1 in fetch data phase at 0x40 → ERROR, err_addr=0x40. Separately, HREADY stuck low with TIMEOUT_CYCLES=4 → ERROR after 4 low cycles.
- reset=0 asserted during D_DATA → next edge: HTRANS=00, bus_error=0, state IDLE. The operation is not retired.

Source files
------------

// File: rtl/ahb_shared_bus_sequencer_if.sv
// Core-side handshake and AHB-Lite master signals for the shared fetch/data bus sequencer.
interface ahb_shared_bus_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic [31:0]           instr_out;
    logic                  instr_valid;
    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_size;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  retire;
    logic                  bus_error;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  enable, pc_in, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
               HRDATA, HREADY, HRESP,
        output instr_out, instr_valid, rdata, rdata_valid, retire, bus_error, err_addr,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output enable, pc_in, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
               HRDATA, HREADY, HRESP,
        input  instr_out, instr_valid, rdata, rdata_valid, retire, bus_error, err_addr,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_shared_bus_sequencer.sv
// Fetch -> execute -> optional data access sequencer sharing one AHB-Lite master port.
// Traps on HRESP, a stuck data phase, or a misaligned/illegal data access.
module ahb_shared_bus_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic i_clock,
    input logic i_reset,
    ahb_shared_bus_sequencer_if.master bus
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_F_ADDR, S_F_DATA, S_EXEC, S_D_ADDR, S_D_DATA, S_ERROR
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_haddr, r_addr_q, r_err_addr, w_haddr;
    logic                  r_hwrite, r_we_q, w_hwrite;
    logic [2:0]            r_hsize, w_hsize;
    logic [1:0]            r_size_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic [31:0]           r_instr, w_fetch_word;
    logic [CW-1:0]         r_cnt;
    logic                  w_data_phase, w_done, w_timeout, w_legal;

    // In a 64-bit bus the fetched word sits in the lane selected by address bit 2.
    generate
        if (DATA_WIDTH == 64) begin : g_lane64
            assign w_fetch_word = r_haddr[2] ? bus.HRDATA[63:32] : bus.HRDATA[31:0];
        end else begin : g_lane32
            assign w_fetch_word = bus.HRDATA[31:0];
        end
    endgenerate

    always_comb begin
        w_legal = 1'b0;
        case (bus.mem_size)
            2'b00: w_legal = 1'b1;
            2'b01: w_legal = ~bus.mem_addr[0];
            2'b10: w_legal = (bus.mem_addr[1:0] == 2'b00);
            2'b11: w_legal = (DATA_WIDTH == 64) && (bus.mem_addr[2:0] == 3'b000);
            default: w_legal = 1'b0;
        endcase
    end

    assign w_data_phase = (r_state == S_F_DATA) || (r_state == S_D_DATA);
    assign w_done       = w_data_phase && bus.HREADY && !bus.HRESP;
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && w_data_phase && !bus.HREADY &&
                          (32'(r_cnt) == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.enable) w_next = S_F_ADDR;
            S_F_ADDR: w_next = S_F_DATA;
            S_F_DATA: begin
                if (bus.HRESP || w_timeout) w_next = S_ERROR;
                else if (bus.HREADY)        w_next = S_EXEC;
            end
            S_EXEC: begin
                if (!bus.mem_req)  w_next = bus.enable ? S_F_ADDR : S_IDLE;
                else if (w_legal)  w_next = S_D_ADDR;
                else               w_next = S_ERROR;
            end
            S_D_ADDR: w_next = S_D_DATA;
            S_D_DATA: begin
                if (bus.HRESP || w_timeout) w_next = S_ERROR;
                else if (bus.HREADY)        w_next = bus.enable ? S_F_ADDR : S_IDLE;
            end
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    // Address-phase controls are live only in the two address states and hold otherwise.
    always_comb begin
        w_haddr  = r_haddr;
        w_hwrite = r_hwrite;
        w_hsize  = r_hsize;
        if (r_state == S_F_ADDR) begin
            w_haddr  = bus.pc_in;
            w_hwrite = 1'b0;
            w_hsize  = 3'b010;
        end else if (r_state == S_D_ADDR) begin
            w_haddr  = r_addr_q;
            w_hwrite = r_we_q;
            w_hsize  = {1'b0, r_size_q};
        end
    end

    assign bus.HADDR       = w_haddr;
    assign bus.HWRITE      = w_hwrite;
    assign bus.HSIZE       = w_hsize;
    assign bus.HTRANS      = ((r_state == S_F_ADDR) || (r_state == S_D_ADDR)) ? 2'b10 : 2'b00;
    assign bus.HWDATA      = r_wdata_q;
    assign bus.instr_out   = r_instr;
    assign bus.instr_valid = (r_state == S_EXEC);
    assign bus.retire      = ((r_state == S_EXEC) && !bus.mem_req) || ((r_state == S_D_DATA) && w_done);
    assign bus.rdata       = bus.HRDATA;
    assign bus.rdata_valid = (r_state == S_D_DATA) && w_done && !r_we_q;
    assign bus.bus_error   = (r_state == S_ERROR);
    assign bus.err_addr    = r_err_addr;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'b010;
            r_addr_q   <= '0;
            r_we_q     <= 1'b0;
            r_size_q   <= 2'b00;
            r_wdata_q  <= '0;
            r_instr    <= 32'h0000_0013;
            r_err_addr <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_F_ADDR) || (r_state == S_D_ADDR)) begin
                r_haddr  <= w_haddr;
                r_hwrite <= w_hwrite;
                r_hsize  <= w_hsize;
            end
            if (r_state == S_EXEC) begin
                r_addr_q  <= bus.mem_addr;
                r_we_q    <= bus.mem_we;
                r_size_q  <= bus.mem_size;
                r_wdata_q <= bus.mem_wdata;
            end
            if ((r_state == S_F_DATA) && w_done)
                r_instr <= w_fetch_word;
            // EXEC traps report the offending data address; bus traps report the phase address.
            if ((w_next == S_ERROR) && (r_state != S_ERROR))
                r_err_addr <= (r_state == S_EXEC) ? bus.mem_addr : r_haddr;
            if (w_data_phase && !bus.HREADY && (w_next == r_state))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_ahb_shared_bus_sequencer.sv
// Directed per-cycle vector table on a 32-bit instance, plus hand sequences on a 64-bit one.
module tb_ahb_shared_bus_sequencer;
    logic clk = 1'b0;
    logic rst32, rst64;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ahb_shared_bus_sequencer_if b32 ();
    ahb_shared_bus_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) b64 ();

    ahb_shared_bus_sequencer u32 (.i_clock(clk), .i_reset(rst32), .bus(b32));
    ahb_shared_bus_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(4))
        u64 (.i_clock(clk), .i_reset(rst64), .bus(b64));

    typedef struct {
        logic [31:0] rst, en, pc, mreq, mwe, msz, maddr, mwd, hrd, rdy, rsp;
        logic [31:0] e_trans, e_haddr, e_hwr, e_hsz, e_hwd, e_iv, e_rt, e_rv, e_be, e_iout, e_ea;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // rst en pc | mreq we sz maddr wdata | hrdata rdy resp || trans haddr hwr hsz hwdata | iv rt rv be iout eaddr
        tbl = '{
            '{1,0,0,     0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,0,     0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,0,     0,0,0,0,0,             0,1,0,           2,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,0,     0,0,0,0,0,             'h00500093,1,0,  0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,0,     0,0,0,0,0,             0,1,0,           0,0,0,2,0,                1,1,0,0,'h00500093,0},
            '{1,1,4,     0,0,0,0,0,             0,1,0,           2,4,0,2,0,                0,0,0,0,'h00500093,0},
            '{1,1,4,     0,0,0,0,0,             'h00112023,1,0,  0,4,0,2,0,                0,0,0,0,'h00500093,0},
            '{1,1,4,     1,1,2,'h1000,'hDEADBEEF, 0,1,0,         0,4,0,2,0,                1,0,0,0,'h00112023,0},
            '{1,1,4,     0,0,0,0,0,             0,1,0,           2,'h1000,1,2,'hDEADBEEF,  0,0,0,0,'h00112023,0},
            '{1,1,4,     0,0,0,0,0,             0,0,0,           0,'h1000,1,2,'hDEADBEEF,  0,0,0,0,'h00112023,0},
            '{1,1,4,     0,0,0,0,0,             0,0,0,           0,'h1000,1,2,'hDEADBEEF,  0,0,0,0,'h00112023,0},
            '{1,1,4,     0,0,0,0,0,             0,1,0,           0,'h1000,1,2,'hDEADBEEF,  0,1,0,0,'h00112023,0},
            '{1,1,8,     0,0,0,0,0,             0,1,0,           2,8,0,2,'hDEADBEEF,       0,0,0,0,'h00112023,0},
            '{1,1,8,     0,0,0,0,0,             'h00012183,1,0,  0,8,0,2,'hDEADBEEF,       0,0,0,0,'h00112023,0},
            '{1,1,8,     1,0,1,'h2002,0,        0,1,0,           0,8,0,2,'hDEADBEEF,       1,0,0,0,'h00012183,0},
            '{1,1,8,     0,0,0,0,0,             0,1,0,           2,'h2002,0,1,0,           0,0,0,0,'h00012183,0},
            '{1,0,8,     0,0,0,0,0,             'h0000BEEF,1,0,  0,'h2002,0,1,0,           0,1,1,0,'h00012183,0},
            '{1,0,8,     0,0,0,0,0,             0,1,0,           0,'h2002,0,1,0,           0,0,0,0,'h00012183,0},
            '{1,1,'h10,  0,0,0,0,0,             0,1,0,           0,'h2002,0,1,0,           0,0,0,0,'h00012183,0},
            '{1,1,'h10,  0,0,0,0,0,             0,1,0,           2,'h10,0,2,0,             0,0,0,0,'h00012183,0},
            '{1,1,'h10,  0,0,0,0,0,             'h13,1,0,        0,'h10,0,2,0,             0,0,0,0,'h00012183,0},
            '{1,1,'h10,  1,0,3,'h3000,0,        0,1,0,           0,'h10,0,2,0,             1,0,0,0,'h13,0},
            '{1,1,'h10,  0,0,0,0,0,             0,1,0,           0,'h10,0,2,0,             0,0,0,1,'h13,'h3000},
            '{1,1,'h10,  0,0,0,0,0,             0,1,0,           0,'h10,0,2,0,             0,0,0,1,'h13,'h3000},
            '{0,1,'h10,  0,0,0,0,0,             0,1,0,           0,'h10,0,2,0,             0,0,0,1,'h13,'h3000},
            '{1,1,'h20,  0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,'h20,  0,0,0,0,0,             0,1,0,           2,'h20,0,2,0,             0,0,0,0,'h13,0},
            '{1,1,'h20,  0,0,0,0,0,             'h13,1,0,        0,'h20,0,2,0,             0,0,0,0,'h13,0},
            '{1,1,'h20,  1,0,2,'h1002,0,        0,1,0,           0,'h20,0,2,0,             1,0,0,0,'h13,0},
            '{1,1,'h20,  0,0,0,0,0,             0,1,0,           0,'h20,0,2,0,             0,0,0,1,'h13,'h1002},
            '{1,1,'h20,  0,0,0,0,0,             0,1,0,           0,'h20,0,2,0,             0,0,0,1,'h13,'h1002},
            '{0,1,'h20,  0,0,0,0,0,             0,1,0,           0,'h20,0,2,0,             0,0,0,1,'h13,'h1002},
            '{1,1,'h40,  0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,'h40,  0,0,0,0,0,             0,1,0,           2,'h40,0,2,0,             0,0,0,0,'h13,0},
            '{1,1,'h40,  0,0,0,0,0,             0,0,1,           0,'h40,0,2,0,             0,0,0,0,'h13,0},
            '{1,1,'h40,  0,0,0,0,0,             0,1,0,           0,'h40,0,2,0,             0,0,0,1,'h13,'h40},
            '{0,1,'h40,  0,0,0,0,0,             0,1,0,           0,'h40,0,2,0,             0,0,0,1,'h13,'h40},
            '{1,1,'h50,  0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,1,'h50,  0,0,0,0,0,             0,1,0,           2,'h50,0,2,0,             0,0,0,0,'h13,0},
            '{1,1,'h50,  0,0,0,0,0,             'h13,1,0,        0,'h50,0,2,0,             0,0,0,0,'h13,0},
            '{1,1,'h50,  1,1,0,'h1003,'hAA,     0,1,0,           0,'h50,0,2,0,             1,0,0,0,'h13,0},
            '{1,1,'h50,  0,0,0,0,0,             0,1,0,           2,'h1003,1,0,'hAA,        0,0,0,0,'h13,0},
            '{0,1,'h50,  0,0,0,0,0,             0,0,0,           0,'h1003,1,0,'hAA,        0,0,0,0,'h13,0},
            '{1,0,'h50,  0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0},
            '{1,0,'h50,  0,0,0,0,0,             0,1,0,           0,0,0,2,0,                0,0,0,0,'h13,0}
        };

        rst32 = 1'b0; rst64 = 1'b0;
        b32.enable = 1'b0; b32.pc_in = '0; b32.mem_req = 1'b0; b32.mem_we = 1'b0;
        b32.mem_size = 2'b00; b32.mem_addr = '0; b32.mem_wdata = '0;
        b32.HRDATA = '0; b32.HREADY = 1'b1; b32.HRESP = 1'b0;
        b64.enable = 1'b0; b64.pc_in = '0; b64.mem_req = 1'b0; b64.mem_we = 1'b0;
        b64.mem_size = 2'b00; b64.mem_addr = '0; b64.mem_wdata = '0;
        b64.HRDATA = '0; b64.HREADY = 1'b1; b64.HRESP = 1'b0;
        tick();
        tick();

        foreach (tbl[i]) begin
            tick();
            rst32          = tbl[i].rst[0];
            b32.enable     = tbl[i].en[0];
            b32.pc_in      = tbl[i].pc;
            b32.mem_req    = tbl[i].mreq[0];
            b32.mem_we     = tbl[i].mwe[0];
            b32.mem_size   = tbl[i].msz[1:0];
            b32.mem_addr   = tbl[i].maddr;
            b32.mem_wdata  = tbl[i].mwd;
            b32.HRDATA     = tbl[i].hrd;
            b32.HREADY     = tbl[i].rdy[0];
            b32.HRESP      = tbl[i].rsp[0];
            #2;
            chk($sformatf("r%0d HTRANS", i),      64'(b32.HTRANS),      64'(tbl[i].e_trans));
            chk($sformatf("r%0d HADDR", i),       64'(b32.HADDR),       64'(tbl[i].e_haddr));
            chk($sformatf("r%0d HWRITE", i),      64'(b32.HWRITE),      64'(tbl[i].e_hwr));
            chk($sformatf("r%0d HSIZE", i),       64'(b32.HSIZE),       64'(tbl[i].e_hsz));
            chk($sformatf("r%0d HWDATA", i),      64'(b32.HWDATA),      64'(tbl[i].e_hwd));
            chk($sformatf("r%0d instr_valid", i), 64'(b32.instr_valid), 64'(tbl[i].e_iv));
            chk($sformatf("r%0d retire", i),      64'(b32.retire),      64'(tbl[i].e_rt));
            chk($sformatf("r%0d rdata_valid", i), 64'(b32.rdata_valid), 64'(tbl[i].e_rv));
            chk($sformatf("r%0d bus_error", i),   64'(b32.bus_error),   64'(tbl[i].e_be));
            chk($sformatf("r%0d instr_out", i),   64'(b32.instr_out),   64'(tbl[i].e_iout));
            chk($sformatf("r%0d err_addr", i),    64'(b32.err_addr),    64'(tbl[i].e_ea));
        end

        // 64-bit bus: upper-lane fetch at 0x4, then a dword load at 0x8.
        tick();
        rst64 = 1'b1; b64.enable = 1'b1; b64.pc_in = 32'h4;
        b64.HRDATA = {32'h0081_3183, 32'hFFFF_FFFF};
        tick(); #2;
        chk("l64 fetch HTRANS", 64'(b64.HTRANS), 64'd2);
        chk("l64 fetch HADDR", 64'(b64.HADDR), 64'h4);
        tick(); #2;
        tick();
        b64.mem_req = 1'b1; b64.mem_we = 1'b0; b64.mem_size = 2'b11; b64.mem_addr = 32'h8;
        #2;
        chk("l64 instr_valid", 64'(b64.instr_valid), 64'd1);
        chk("l64 instr_out lane", 64'(b64.instr_out), 64'h0081_3183);
        chk("l64 exec retire", 64'(b64.retire), 64'd0);
        tick();
        b64.mem_req = 1'b0;
        #2;
        chk("l64 data HTRANS", 64'(b64.HTRANS), 64'd2);
        chk("l64 data HSIZE", 64'(b64.HSIZE), 64'd3);
        chk("l64 data HADDR", 64'(b64.HADDR), 64'h8);
        tick();
        b64.HRDATA = 64'h1122_3344_5566_7788; b64.enable = 1'b0;
        #2;
        chk("l64 rdata_valid", 64'(b64.rdata_valid), 64'd1);
        chk("l64 retire", 64'(b64.retire), 64'd1);
        chk("l64 rdata", b64.rdata, 64'h1122_3344_5566_7788);

        // Fetch data phase stuck low: trap after exactly 4 low cycles.
        tick();
        b64.enable = 1'b1; b64.pc_in = 32'h60;
        #2;
        chk("to idle HTRANS", 64'(b64.HTRANS), 64'd0);
        tick(); #2;
        chk("to fetch HADDR", 64'(b64.HADDR), 64'h60);
        for (int k = 0; k < 4; k++) begin
            tick();
            b64.HREADY = 1'b0;
            #2;
            chk($sformatf("to low%0d bus_error", k), 64'(b64.bus_error), 64'd0);
        end
        tick(); #2;
        chk("to trap bus_error", 64'(b64.bus_error), 64'd1);
        chk("to trap err_addr", 64'(b64.err_addr), 64'h60);

        // HRESP during a store data phase reports the data address.
        tick();
        rst64 = 1'b0; b64.HREADY = 1'b1;
        tick();
        rst64 = 1'b1; b64.pc_in = 32'h0; b64.HRDATA = '0;
        tick();
        tick();
        tick();
        b64.mem_req = 1'b1; b64.mem_we = 1'b1; b64.mem_size = 2'b10;
        b64.mem_addr = 32'h10; b64.mem_wdata = 64'h55;
        tick();
        b64.mem_req = 1'b0;
        #2;
        chk("hresp D_ADDR HWRITE", 64'(b64.HWRITE), 64'd1);
        tick();
        b64.HRESP = 1'b1;
        #2;
        chk("hresp no retire", 64'(b64.retire), 64'd0);
        tick();
        b64.HRESP = 1'b0;
        #2;
        chk("hresp bus_error", 64'(b64.bus_error), 64'd1);
        chk("hresp err_addr", 64'(b64.err_addr), 64'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
